// File: rtl/muldiv_pkg.sv
// Shared operation codes and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    // 4-bit operation codes issued by the decode stage next to the ALU codes
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_t;

    // True for the operations that run through the iterative datapath
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the operations that interpret their operands as two's complement
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // True for the divide family
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of unsigned shift-add multiply or restoring
// shift-subtract divide over a shared 2*WIDTH-bit accumulator.
//   multiply: acc = {partial product high half, remaining multiplier bits}
//   divide  : acc = {partial remainder, dividend bits / quotient bits}
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    // Single step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        // Restored remainder is always below the divisor, so the low WIDTH bits suffice
        diff    = shifted[WIDTH-1:0] - operand;
        if (is_div) begin
            if (fits) begin
                acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative multiply/divide sequencer owning HI/LO. One op per start pulse,
// busy for WIDTH+1 cycles; MTHI/MTLO write immediately while idle.
module muldiv_controller
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    logic [1:0]         state_reg, state_next;
    logic [CW-1:0]      counter_reg;
    logic               busy_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opb_reg, orig_a_reg;
    logic               is_div_reg, neg_res_reg, neg_rem_reg, div_zero_reg;

    logic               accept_iter, mthi_we, mtlo_we, fix_we;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rem;

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // Magnitudes of the operands; unsigned ops pass the raw values through
    always_comb begin
        a_neg = is_signed_op(op) & A[WIDTH-1];
        b_neg = is_signed_op(op) & B[WIDTH-1];
        a_mag = a_neg ? (~A + 1'b1) : A;
        b_mag = b_neg ? (~B + 1'b1) : B;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_reg),
        .acc_in  (acc_reg),
        .operand (opb_reg),
        .acc_out (acc_next)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; cancel always forces a return to idle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept_iter) state_next = ST_ITER;
            ST_ITER: begin
                if (cancel) begin
                    state_next = ST_IDLE;
                end else if (counter_reg == CW'(WIDTH - 1)) begin
                    state_next = ST_FIXUP;
                end
            end
            ST_FIXUP: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Per-state strobes: accept/MT* only while idle and not cancelled, HI/LO write in FIXUP
    always_comb begin
        accept_iter = 1'b0;
        mthi_we     = 1'b0;
        mtlo_we     = 1'b0;
        fix_we      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !cancel) begin
                    accept_iter = is_iter_op(op);
                    mthi_we     = (op == MD_MTHI);
                    mtlo_we     = (op == MD_MTLO);
                end
            end
            ST_FIXUP: fix_we = !cancel;
            default: ;
        endcase
    end

    // Signed results: product/quotient negate on differing signs, remainder follows dividend
    always_comb begin
        product = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
        quot    = neg_res_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem     = neg_rem_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
    end

    // Iteration datapath: latch operands on accept, step the accumulator in ITER
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg      <= '0;
            opb_reg      <= '0;
            orig_a_reg   <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            counter_reg  <= '0;
        end else if (accept_iter) begin
            acc_reg      <= {{WIDTH{1'b0}}, a_mag};
            opb_reg      <= b_mag;
            orig_a_reg   <= A;
            is_div_reg   <= is_div_op(op);
            neg_res_reg  <= a_neg ^ b_neg;
            neg_rem_reg  <= a_neg;
            div_zero_reg <= (B == '0);
            counter_reg  <= '0;
        end else if (state_reg == ST_ITER) begin
            acc_reg      <= acc_next;
            counter_reg  <= counter_reg + CW'(1);
        end
    end

    // HI/LO and busy: written only by MT* in idle or by a completed FIXUP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_reg   <= '0;
            lo_reg   <= '0;
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != ST_IDLE);
            if (mthi_we) hi_reg <= A;
            if (mtlo_we) lo_reg <= A;
            if (fix_we) begin
                if (!is_div_reg) begin
                    {hi_reg, lo_reg} <= product;
                end else if (div_zero_reg) begin
                    hi_reg <= orig_a_reg;
                    lo_reg <= '1;
                end else begin
                    hi_reg <= rem;
                    lo_reg <= quot;
                end
            end
        end
    end

endmodule
